// File: rtl/hub75_pkg.sv
// Shared types and constants for the HUB75 receive-side capture block.
package hub75_pkg;

    localparam int ROW_W    = 4;
    localparam int OE_CNT_W = 16;

    typedef enum logic {
        DRAIN_IDLE,
        DRAIN_BUSY
    } drain_state_t;

    typedef struct packed {
        logic r;
        logic g;
        logic b;
    } seg_rgb_t;

    function automatic logic [ROW_W-1:0] row_addr(input logic a, input logic b,
                                                  input logic c, input logic d);
        return {d, c, b, a};
    endfunction

endpackage

// File: rtl/hub75_capture_if.sv
// Pixel record stream produced by hub75_capture: valid/ready plus row, column, plane and RGB.
interface hub75_capture_if
    import hub75_pkg::*;
#(
    parameter int COL_W   = 6,
    parameter int PLANE_W = 3,
    parameter int RGB_W   = 6
);
    logic               px_valid;
    logic               px_ready;
    logic [ROW_W-1:0]   px_row;
    logic [COL_W-1:0]   px_col;
    logic [PLANE_W-1:0] px_plane;
    logic [RGB_W-1:0]   px_rgb;

    modport master (output px_valid, px_row, px_col, px_plane, px_rgb, input px_ready);
    modport slave  (input px_valid, px_row, px_col, px_plane, px_rgb, output px_ready);
endinterface

// File: rtl/hub75_sync_edge.sv
// Two-flop synchronizer for one edge-detected level plus a payload captured alongside it,
// so the payload is aligned with the registered rising-edge pulse.
module hub75_sync_edge #(
    parameter int PAYLOAD_W = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 level,
    input  logic [PAYLOAD_W-1:0] payload,
    output logic                 rise,
    output logic [PAYLOAD_W-1:0] payload_q
);
    logic [PAYLOAD_W:0] meta;
    logic [PAYLOAD_W:0] sync;
    logic               level_q;

    // NOTE: non-blocking assignments so each stage takes the previous stage's old value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta      <= '0;
            sync      <= '0;
            level_q   <= 1'b0;
            rise      <= 1'b0;
            payload_q <= '0;
        end else begin
            meta      <= {payload, level};
            sync      <= meta;
            level_q   <= sync[0];
            rise      <= sync[0] & ~level_q;
            payload_q <= sync[PAYLOAD_W:1];
        end
    end

endmodule

// File: rtl/hub75_capture.sv
// HUB75 receive-side capture: rebuilds shifted lines into a double buffer and streams
// per-pixel records. Define HUB75_CAPTURE_OE_MEAS_EN to enable the OE-low cycle counter.
module hub75_capture
    import hub75_pkg::*;
#(
    parameter int hpixel_p   = 64,
    parameter int vpixel_p   = 64,
    parameter int bpp_p      = 8,
    parameter int segments_p = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_enable,
    input  logic                i_hub_clk,
    input  logic                i_stb,
    input  logic                i_oe,
    input  logic                i_a,
    input  logic                i_b,
    input  logic                i_c,
    input  logic                i_d,
    input  logic                i_r1,
    input  logic                i_g1,
    input  logic                i_b1,
    input  logic                i_r2,
    input  logic                i_g2,
    input  logic                i_b2,
    hub75_capture_if.master     px,
    output logic [OE_CNT_W-1:0] o_oe_cycles,
    output logic                o_err_underrun,
    output logic                o_err_overrun,
    output logic                o_err_drop
);
    localparam int COL_W   = $clog2(hpixel_p);
    localparam int CNT_W   = $clog2(hpixel_p + 1);
    localparam int PLANE_W = $clog2(bpp_p);
    localparam int RGB_W   = 3 * segments_p;
    // Panel height is informational only; the row address width is fixed by A-D.
    localparam int vpixel_unused = vpixel_p;

    seg_rgb_t [segments_p-1:0] pins_rgb;
    logic                      hub_rise;
    logic                      stb_rise;
    logic [RGB_W-1:0]          pix_sync;
    logic [ROW_W:0]            ctl_sync;
    logic [ROW_W-1:0]          row_in;
    logic                      oe_low;

    assign pins_rgb[0] = '{r: i_r1, g: i_g1, b: i_b1};
    assign pins_rgb[1] = '{r: i_r2, g: i_g2, b: i_b2};

    hub75_sync_edge #(.PAYLOAD_W(RGB_W)) u_clk_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .level     (i_hub_clk),
        .payload   (pins_rgb),
        .rise      (hub_rise),
        .payload_q (pix_sync)
    );

    hub75_sync_edge #(.PAYLOAD_W(ROW_W + 1)) u_stb_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .level     (i_stb),
        .payload   ({i_oe, row_addr(i_a, i_b, i_c, i_d)}),
        .rise      (stb_rise),
        .payload_q (ctl_sync)
    );

    assign row_in = ctl_sync[ROW_W-1:0];
    assign oe_low = ~ctl_sync[ROW_W];

    logic [RGB_W-1:0]   line_buf [2][hpixel_p];
    logic               fill_sel;
    logic [CNT_W-1:0]   col_cnt;
    logic [CNT_W-1:0]   col_after;
    logic               over_seen;
    logic               stb_seen;
    logic [ROW_W-1:0]   row_q;
    logic [PLANE_W-1:0] plane_q;
    logic [PLANE_W-1:0] plane_next;
    logic               wr_en;
    logic               line_stb;
    logic               swap;
    drain_state_t       state;

    // NOTE: every variable gets a default first so no path through the block infers a latch.
    always_comb begin
        wr_en      = i_enable && hub_rise && (col_cnt < CNT_W'(hpixel_p));
        col_after  = wr_en ? col_cnt + CNT_W'(1) : col_cnt;
        line_stb   = i_enable && stb_rise;
        swap       = line_stb && (state == DRAIN_IDLE);
        plane_next = '0;
        if (stb_seen && (row_in == row_q))
            plane_next = (plane_q == PLANE_W'(bpp_p - 1)) ? '0 : plane_q + PLANE_W'(1);
    end

    // A clock edge coinciding with STB is written before the line is handed over,
    // because the clear below targets the other buffer (or the dropped one, last write wins).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the line store is reset so underrun columns of the very first line read as 0.
            for (int s = 0; s < 2; s++)
                for (int c = 0; c < hpixel_p; c++)
                    line_buf[s][c] <= '0;
            fill_sel       <= 1'b0;
            col_cnt        <= '0;
            over_seen      <= 1'b0;
            stb_seen       <= 1'b0;
            row_q          <= '0;
            plane_q        <= '0;
            o_err_underrun <= 1'b0;
            o_err_overrun  <= 1'b0;
            o_err_drop     <= 1'b0;
        end else if (!i_enable) begin
            col_cnt        <= '0;
            over_seen      <= 1'b0;
            stb_seen       <= 1'b0;
            row_q          <= '0;
            plane_q        <= '0;
            o_err_underrun <= 1'b0;
            o_err_overrun  <= 1'b0;
            o_err_drop     <= 1'b0;
        end else begin
            o_err_underrun <= 1'b0;
            o_err_overrun  <= 1'b0;
            o_err_drop     <= 1'b0;
            if (wr_en) begin
                line_buf[fill_sel][col_cnt[COL_W-1:0]] <= pix_sync;
                col_cnt <= col_cnt + CNT_W'(1);
            end else if (hub_rise && !over_seen) begin
                o_err_overrun <= 1'b1;
                over_seen     <= 1'b1;
            end
            if (line_stb) begin
                row_q          <= row_in;
                plane_q        <= plane_next;
                stb_seen       <= 1'b1;
                o_err_underrun <= (col_after < CNT_W'(hpixel_p));
                col_cnt        <= '0;
                over_seen      <= 1'b0;
                if (swap) begin
                    fill_sel <= ~fill_sel;
                    for (int c = 0; c < hpixel_p; c++)
                        line_buf[~fill_sel][c] <= '0;
                end else begin
                    o_err_drop <= 1'b1;
                    for (int c = 0; c < hpixel_p; c++)
                        line_buf[fill_sel][c] <= '0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= DRAIN_IDLE;
            px.px_valid <= 1'b0;
            px.px_col   <= '0;
            px.px_row   <= '0;
            px.px_plane <= '0;
        end else if (!i_enable) begin
            state       <= DRAIN_IDLE;
            px.px_valid <= 1'b0;
            px.px_col   <= '0;
        end else begin
            case (state)
                DRAIN_IDLE: begin
                    if (swap) begin
                        state       <= DRAIN_BUSY;
                        px.px_valid <= 1'b1;
                        px.px_col   <= '0;
                        px.px_row   <= row_in;
                        px.px_plane <= plane_next;
                    end
                end
                DRAIN_BUSY: begin
                    if (px.px_ready) begin
                        if (px.px_col == COL_W'(hpixel_p - 1)) begin
                            state       <= DRAIN_IDLE;
                            px.px_valid <= 1'b0;
                            px.px_col   <= '0;
                        end else begin
                            px.px_col <= px.px_col + COL_W'(1);
                        end
                    end
                end
                default: begin
                    state       <= DRAIN_IDLE;
                    px.px_valid <= 1'b0;
                end
            endcase
        end
    end

    // The drain buffer is never written while busy, so the record is a direct read of it.
    assign px.px_rgb = px.px_valid ? line_buf[~fill_sel][px.px_col] : '0;

`ifdef HUB75_CAPTURE_OE_MEAS_EN
    logic [OE_CNT_W-1:0] oe_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            oe_cnt      <= '0;
            o_oe_cycles <= '0;
        end else if (!i_enable) begin
            oe_cnt <= '0;
        end else if (line_stb) begin
            o_oe_cycles <= oe_cnt;
            oe_cnt      <= OE_CNT_W'(oe_low);
        end else if (oe_low && (oe_cnt != '1)) begin
            oe_cnt <= oe_cnt + OE_CNT_W'(1);
        end
    end
`else
    logic oe_unused;
    assign oe_unused   = oe_low;
    assign o_oe_cycles = '0;
`endif

endmodule

// File: tb/tb_hub75_capture.sv
// Scoreboard bench for hub75_capture: directed lines push expected records, a monitor compares.
`timescale 1ns/1ps
module tb_hub75_capture;
    import hub75_pkg::*;

    localparam int H   = 64;
    localparam int BPP = 8;

    typedef struct packed {
        logic [3:0] row;
        logic [5:0] col;
        logic [2:0] plane;
        logic [5:0] rgb;
    } rec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic i_enable = 1'b1;
    logic hub_clk = 1'b0, stb = 1'b0, oe = 1'b1;
    logic pa = 1'b0, pb = 1'b0, pc = 1'b0, pd = 1'b0;
    logic r1 = 1'b0, g1 = 1'b0, b1 = 1'b0, r2 = 1'b0, g2 = 1'b0, b2 = 1'b0;
    logic [15:0] oe_cycles;
    logic err_u, err_o, err_d;

    int n_checks = 0, n_fail = 0;
    int cnt_u = 0, cnt_o = 0, cnt_d = 0;
    int exp_u = 0, exp_o = 0, exp_d = 0;
    rec_t exp_q[$];
    bit mdl_seen = 0;
    int mdl_row = 0, mdl_plane = 0;

    hub75_capture_if #(.COL_W(6), .PLANE_W(3), .RGB_W(6)) px ();

    hub75_capture #(.hpixel_p(H), .vpixel_p(64), .bpp_p(BPP), .segments_p(2)) dut (
        .clk(clk), .rst_n(rst_n), .i_enable(i_enable),
        .i_hub_clk(hub_clk), .i_stb(stb), .i_oe(oe),
        .i_a(pa), .i_b(pb), .i_c(pc), .i_d(pd),
        .i_r1(r1), .i_g1(g1), .i_b1(b1), .i_r2(r2), .i_g2(g2), .i_b2(b2),
        .px(px),
        .o_oe_cycles(oe_cycles),
        .o_err_underrun(err_u), .o_err_overrun(err_o), .o_err_drop(err_d)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
        end
    endtask

    // Pin pattern {r1,g1,b1,r2,g2,b2} for a column.
    function automatic logic [5:0] pat_pins(input int kind, input int col);
        logic [6:0] c;
        c = 7'(col);
        case (kind)
            0:       return {c[0], 1'b0, 1'b0, 1'b0, c[1], 1'b0};
            1:       return {1'b0, c[0], c[2], ~c[1], 1'b0, c[3]};
            2:       return c[5:0];
            default: return 6'b0;
        endcase
    endfunction

    // Expected record rgb = {R2,G2,B2,R1,G1,B1}, worked out by hand per pattern.
    function automatic logic [5:0] exp_rgb(input int kind, input int col);
        logic [6:0] c;
        c = 7'(col);
        case (kind)
            0:       return {1'b0, c[1], 1'b0, c[0], 1'b0, 1'b0};
            1:       return {~c[1], 1'b0, c[3], 1'b0, c[0], c[2]};
            2:       return {c[2:0], c[5:3]};
            default: return 6'b0;
        endcase
    endfunction

    always @(negedge clk) begin
        rec_t act;
        if (rst_n) begin
            if (err_u) cnt_u++;
            if (err_o) cnt_o++;
            if (err_d) cnt_d++;
            if (px.px_valid) begin
                act = '{px.px_row, px.px_col, px.px_plane, px.px_rgb};
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL record: unexpected row=%0d col=%0d plane=%0d rgb=%02h",
                             act.row, act.col, act.plane, act.rgb);
                end else begin
                    if (act !== exp_q[0]) begin
                        n_fail++;
                        $display("FAIL record: got row=%0d col=%0d plane=%0d rgb=%02h expected row=%0d col=%0d plane=%0d rgb=%02h",
                                 act.row, act.col, act.plane, act.rgb,
                                 exp_q[0].row, exp_q[0].col, exp_q[0].plane, exp_q[0].rgb);
                    end
                    if (px.px_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic strobe(input int row);
        @(negedge clk);
        {pd, pc, pb, pa} = 4'(row);
        stb = 1'b1;
        repeat (2) @(negedge clk);
        stb = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_line(input int row, input int ncols, input int kind, input bit drains);
        rec_t r;
        @(negedge clk);
        for (int i = 0; i < ncols; i++) begin
            {r1, g1, b1, r2, g2, b2} = pat_pins(kind, i);
            hub_clk = 1'b0;
            repeat (2) @(negedge clk);
            hub_clk = 1'b1;
            repeat (2) @(negedge clk);
        end
        hub_clk = 1'b0;
        {r1, g1, b1, r2, g2, b2} = 6'b0;
        if (mdl_seen && row == mdl_row) mdl_plane = (mdl_plane + 1) % BPP;
        else mdl_plane = 0;
        mdl_seen = 1;
        mdl_row  = row;
        if (drains) begin
            for (int col = 0; col < H; col++) begin
                r.row   = 4'(row);
                r.col   = 6'(col);
                r.plane = 3'(mdl_plane);
                r.rgb   = (col < ncols) ? exp_rgb(kind, col) : 6'b0;
                exp_q.push_back(r);
            end
        end else begin
            exp_d++;
        end
        if (ncols < H) exp_u++;
        if (ncols > H) exp_o++;
        strobe(row);
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || px.px_valid) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({name, "_left"}, exp_q.size(), 0);
        repeat (4) @(negedge clk);
    endtask

    task automatic check_errs(input string name);
        check({name, "_underrun"}, cnt_u, exp_u);
        check({name, "_overrun"}, cnt_o, exp_o);
        check({name, "_drop"}, cnt_d, exp_d);
    endtask

    initial begin
        int n;
        px.px_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_valid", 32'(px.px_valid), 0);
        check("rst_col", 32'(px.px_col), 0);
        check("rst_row", 32'(px.px_row), 0);
        check("rst_plane", 32'(px.px_plane), 0);
        check("rst_rgb", 32'(px.px_rgb), 0);
        check("rst_oe", 32'(oe_cycles), 0);
        check("rst_errs", 32'({err_u, err_o, err_d}), 0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        send_line(3, 64, 0, 1);
        wait_drain("line_r3");
        check_errs("line_r3");

        for (int k = 0; k < 9; k++) begin
            send_line(5, 0, 3, 1);
            wait_drain("plane_r5");
        end
        send_line(6, 0, 3, 1);
        wait_drain("plane_r6");
        check_errs("planes");

        send_line(7, 63, 1, 1);
        wait_drain("underrun");
        check_errs("underrun");
        send_line(7, 66, 1, 1);
        wait_drain("overrun");
        check_errs("overrun");

        px.px_ready = 1'b0;
        send_line(2, 64, 0, 1);
        repeat (10) @(negedge clk);
        check("stall_valid", 32'(px.px_valid), 1);
        send_line(2, 64, 2, 0);
        check("stall_col", 32'(px.px_col), 0);
        px.px_ready = 1'b1;
        wait_drain("drop");
        repeat (20) @(negedge clk);
        check_errs("drop");

        send_line(9, 0, 3, 1);
        wait_drain("oe_a");
        check("oe_first", 32'(oe_cycles), 0);
        @(negedge clk);
        oe = 1'b0;
        repeat (100) @(negedge clk);
        oe = 1'b1;
        send_line(9, 0, 3, 1);
        wait_drain("oe_b");
`ifdef HUB75_CAPTURE_OE_MEAS_EN
        check("oe_cycles", 32'(oe_cycles), 100);
`else
        check("oe_cycles", 32'(oe_cycles), 0);
`endif
        check_errs("oe");

        send_line(4, 64, 1, 1);
        n = 0;
        while (!(px.px_valid && px.px_col == 6'd20) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("reach_col20", 32'(px.px_col), 20);
        rst_n = 1'b0;
        #1;
        check("rst_mid_valid", 32'(px.px_valid), 0);
        exp_q.delete();
        mdl_seen  = 0;
        mdl_plane = 0;
        repeat (3) @(negedge clk);
        check("rst_hold_valid", 32'(px.px_valid), 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        send_line(4, 64, 2, 1);
        wait_drain("post_reset");
        check_errs("post_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hub75_capture.md
# hub75_capture

- Receive-side model of the HUB75 panel interface: samples the HUB75 pins (clock, strobe, OE, row select, RGB) in the system clock domain.
- Reconstructs each shifted line into a double-buffered line store, then streams it out as per-pixel records with row, column, bit-plane index and OE-low duration.
- Sits opposite `hub75_display` for loopback self-check on FPGA and as a scoreboard source in block benches.

## Interface
- `hpixel_p`, 64, pixels shifted per line (columns)
- `vpixel_p`, 64, display height; informational, row width fixed by A–D
- `bpp_p`, 8, bit-planes per colour; plane counter wraps at `bpp_p`
- `segments_p`, 2, RGB pin sets per line (R1G1B1, R2G2B2)

Ports (clk and rst_n first; one clock, reset asynchronous active-low):
- `clk` in 1 system clock
- `rst_n` in 1 asynchronous active-low reset
- `i_enable` in 1 capture enable
- `i_hub_clk`, `i_stb`, `i_oe` in 1 each HUB75 clock, strobe, output enable (active low)
- `i_a`, `i_b`, `i_c`, `i_d` in 1 each row select; row = {D,C,B,A}
- `i_r1`, `i_g1`, `i_b1`, `i_r2`, `i_g2`, `i_b2` in 1 each colour pins
- `o_px_valid` out 1 pixel record valid
- `i_px_ready` in 1 downstream accepts record
- `o_px_row` out 4 row address of the line
- `o_px_col` out $clog2(hpixel_p) column, 0 = first pixel shifted
- `o_px_plane` out $clog2(bpp_p) bit-plane index
- `o_px_rgb` out 3*segments_p {seg1 RGB, seg0 RGB}; seg0 = {R1,G1,B1}
- `o_oe_cycles` out 16 clk cycles OE low during the previous line period, saturating
- `o_err_underrun`, `o_err_overrun`, `o_err_drop` out 1 each single-cycle error pulses

## Operation
- All 13 HUB75 inputs pass through a 2-flop synchronizer. Rising edges of `i_hub_clk` and `i_stb` are detected on the synchronized copies.
- Shift side, per HUB75 clock rising edge, while column count < `hpixel_p`:
  - Write the six synchronized colour bits into the fill buffer at the current column.
  - Increment the column count.
- Further edges on the same line are discarded, and `o_err_overrun` pulses once per line.
- STB rising edge:
  - Latch the row.
  - If column count < `hpixel_p`, pulse `o_err_underrun`; unfilled columns read as 0.
  - If the drain buffer is free, swap buffers; otherwise pulse `o_err_drop` and discard the fill contents.
  - Clear the fill buffer and reset the column count to 0.
- Plane counter, evaluated at each STB:
  - Same row as the previous STB: increment, wrapping `bpp_p-1`→0.
  - Different row: reset to 0.
  - The first STB after reset gives plane 0.
- OE counter:
  - Counts cycles with synchronized OE = 0 between consecutive STB edges; saturates at 16'hFFFF.
  - Snapshotted into `o_oe_cycles` at the STB edge and held until the next STB.
- Drain FSM, IDLE → DRAIN on buffer swap:
  - DRAIN presents columns 0..`hpixel_p-1`; the column advances when `o_px_valid && i_px_ready`.
  - After the last accepted column, return to IDLE and free the buffer.
  - Row and plane are constant for all records of one line.
- `i_enable` = 0 synchronously clears the column count, plane state, drain FSM (`o_px_valid` drops next cycle) and OE counter. Synchronizers keep running.

## Timing
- Reset values: all outputs 0; FSM IDLE; row/plane/column 0.
- Pin sampling: the pin edge is detected 3 clk edges after it is first sampled (2 sync flops + 1 edge register).
- STB latency: first `o_px_valid` is 4 clk cycles after `i_stb` high is first sampled.
- Throughput: one record per cycle while `i_px_ready` = 1. `o_px_valid` and the record fields are held stable while `i_px_ready` = 0.
- Input rate: `i_hub_clk` high and low phases must each be ≥2 clk cycles (driver `i_clk_div` ≥ 1). Data is sampled from the same synchronized vector as the clock edge.
- Simultaneous HUB75 clock edge and STB edge in one cycle: the bit is written first, then the line is latched.
- Error pulses are exactly one cycle wide.
- Reset asserted mid-line or mid-drain: immediate clear; partial line lost, no record emitted.

## Configuration
- `HUB75_CAPTURE_OE_MEAS_EN` defined: OE counter and snapshot are present; `o_oe_cycles` is live.
- Not defined: counter logic removed; `o_oe_cycles` tied to 0. The port always exists.

## Structure
- `hub75_pkg` holds:
  - drain FSM state enum
  - packed pixel-bits struct (per segment {r,g,b})
  - row width constant (4)
  - `OE_CNT_W` = 16
- Sub-module `hub75_sync_edge`: parameterised 2-flop synchronizer with rise-edge output, instantiated for clock and STB.
- Line buffers are registered arrays, 2 × `hpixel_p` × 6 bits.

## Test plan
- Shift 64 columns with R1=col[0], G2=col[1], row 3, then STB → 64 records:
  - col 0..63, row 3, plane 0
  - rgb matches the shifted pattern
  - no error pulses.
- Eight STBs on row 5, then one on row 6 → planes 0..7 on row 5, then plane 0 on row 6. A ninth consecutive row-5 STB wraps to plane 0.
- 63 clocks then STB → `o_err_underrun` pulse; col 63 rgb = 0. 66 clocks then STB → one `o_err_overrun` pulse; first 64 columns kept.
- `i_px_ready` held 0 through a second full line and STB → `o_err_drop`; the first line's col 0 record stays stable. After releasing ready, only the first line drains.
- OE low 100 cycles between two STBs → `o_oe_cycles` = 100 with the macro defined, 0 without.
- `rst_n` low at column 20 of a drain → `o_px_valid` = 0 immediately. After release, a new full line drains from col 0, plane 0.
